// File: rtl/seq_calc_ctrl.sv
// Sequencing controller: folds a valid/ready operand stream into an external
// accumulator register. Optional macro SEQ_CALC_SAT_EN makes add/sub saturate.
module seq_calc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  input  logic [7:0] acc_q,
  output logic       acc_en,
  output logic [7:0] acc_d,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [7:0] count,
  output logic       ovf,
  output logic [1:0] dbg_state
);

  // Handshake: an operand transfers on a rising clk edge where
  // data_valid && data_ready; data_ready is high only in FIRST and ACCUM.
  typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] op_r;
  logic [8:0] sum, diff;
  logic [7:0] fold;
  logic       fold_ovf;

  assign sum  = {1'b0, acc_q} + {1'b0, data_in};
  assign diff = {1'b0, acc_q} - {1'b0, data_in};

  always_comb begin
    fold     = acc_q;
    fold_ovf = 1'b0;
    case (op_r)
      3'b000: begin
        fold_ovf = sum[8];
`ifdef SEQ_CALC_SAT_EN
        fold = sum[8] ? 8'hFF : sum[7:0];
`else
        fold = sum[7:0];
`endif
      end
      3'b001: begin
        fold_ovf = diff[8];
`ifdef SEQ_CALC_SAT_EN
        fold = diff[8] ? 8'h00 : diff[7:0];
`else
        fold = diff[7:0];
`endif
      end
      3'b010:  fold = acc_q & data_in;
      3'b011:  fold = acc_q | data_in;
      3'b100:  fold = acc_q ^ data_in;
      3'b101:  fold = (acc_q > data_in) ? acc_q : data_in;
      3'b110:  fold = (acc_q < data_in) ? acc_q : data_in;
      default: fold = acc_q;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    data_ready = 1'b0;
    acc_en     = 1'b0;
    acc_d      = 8'h00;
    case (state)
      IDLE: if (start) state_nxt = FIRST;
      FIRST: begin
        data_ready = 1'b1;
        if (data_valid) begin
          acc_en    = 1'b1;
          acc_d     = data_in;
          state_nxt = data_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        data_ready = 1'b1;
        if (data_valid) begin
          acc_en = 1'b1;
          acc_d  = fold;
          if (data_last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_r   <= 3'b000;
      count  <= 8'h00;
      ovf    <= 1'b0;
      result <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_r  <= op;
        count <= 8'h00;
        ovf   <= 1'b0;
      end
      if (acc_en) begin
        if (state == FIRST)      count <= 8'd1;
        else if (count != 8'hFF) count <= count + 8'd1;
        if (state == ACCUM && fold_ovf) ovf <= 1'b1;
        // result mirrors the value the accumulator takes on the final write
        if (data_last) result <= acc_d;
      end
    end
  end

endmodule
